plc_updown_counter: RTL and testbench
=====================================

Name: plc_updown_counter

Overview:
Parametrised PLC counter instruction block: the successor to the fixed up/down counter in the timer/counter unit. It counts rising edges on separate count-up and count-down inputs, with run-time mode select (up, down, up/down), load and clear, saturation, and sticky overflow/underflow flags. It sits in the timer/counter peripheral and is driven by the execution unit's counter instructions.

Parameters:
ACC_W, 16, width of accumulator and preset
MAX_VAL, {ACC_W{1'b1}}, saturation ceiling for up counting

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  count enable; clear/load still act when low
mode  in  2  00 off, 01 up (CTU), 10 down (CTD), 11 up/down (CTUD)
preset  in  ACC_W  preset value
cu_in  in  1  count-up input, rising-edge sensitive
cd_in  in  1  count-down input, rising-edge sensitive
load  in  1  synchronous load of preset into acc
clr  in  1  synchronous clear of acc to 0
acc  out  ACC_W  accumulated count
dn  out  1  done
cu  out  1  one-cycle pulse: up count applied
cd  out  1  one-cycle pulse: down count applied
ov  out  1  sticky overflow (up count attempted at MAX_VAL)
un  out  1  sticky underflow (down count attempted at 0)

Behaviour:
- reset low (async): acc=0, cu=0, cd=0, ov=0, un=0, mode_q=00, cu_prev=1, cd_prev=1. Inputs held high through reset release do not count.
- Registers: mode_q <= mode, cu_prev <= cu_in, cd_prev <= cd_in every clk.
- Edge detection: up_ev = cu_in & ~cu_prev; dn_ev = cd_in & ~cd_prev. Both are sampled at the clk edge, and acc is updated at that same edge (1-cycle latency from the sampled high level). Prev registers update even when enable=0, so a held level does not count when enable rises.
- Mode change (mode != mode_q at the edge): acc <= preset if the new mode is 10, else 0. ov, un, cu and cd are cleared. Count events on that edge are ignored. This takes priority over clr and load.
- Priority after mode change: clr > load > count. clr: acc<=0, ov<=0, un<=0. load: acc<=preset, ov<=0, un<=0. cu and cd are 0 on clr/load cycles.
- Count applies only when enable=1 and mode_q != 00:
  - Mode 01 uses up_ev only.
  - Mode 10 uses dn_ev only.
  - Mode 11 uses both. up_ev and dn_ev together cancel: no change, no pulse.
- Up count: if acc == MAX_VAL, acc holds, ov<=1, cu=0. Otherwise acc<=acc+1, cu<=1 for one cycle.
- Down count: if acc == 0, acc holds, un<=1, cd=0. Otherwise acc<=acc-1, cd<=1 for one cycle.
- cu/cd are registered pulses, high for exactly the cycle after the accepted event edge. They are never both high.
- dn is combinational from registered state (unsigned compare):
  - mode_q 01: acc >= preset
  - mode_q 10: acc == 0
  - mode_q 11: acc >= preset
  - mode_q 00: 0
  - preset changes take effect immediately.
- ov/un are sticky until clr, load, mode change or reset.
- Mode 00: acc holds, no counting; clr/load still act.
- Unsigned arithmetic with no wrap-around anywhere.

Test Plan:
- ACC_W=8, mode=01, preset=3: 4 cu_in pulses (high 2 cycles, low 2) -> acc 1,2,3,4. dn rises in the cycle acc=3. cu pulses 4 times, each 1 cycle long.
- mode=10, preset=2, then 3 cd_in pulses -> mode change loads acc=2 → 1 → 0 with dn=1. Third pulse: acc stays 0, un=1, cd stays 0.
- mode=01, load with preset=8'hFF, then 1 cu pulse -> acc stays FF, ov=1. Then clr -> acc=0, ov=0, dn=0 (preset FF).
- mode=11, acc=5: cu_in and cd_in rise on the same edge -> acc stays 5, cu=cd=0. cu then cd separately -> 6 then 5.
- cu_in held high across reset release and across an enable 0→1 transition -> no count. Assert clr and load together -> acc=0.
- Counting at acc=7, drop reset mid-pulse -> all outputs 0 immediately (async). After release with mode still 01 -> mode_q 00→01 change forces acc=0, and the next cu edge gives acc=1.

Source files
------------

// File: rtl/plc_updown_counter.sv
// PLC up/down counter instruction block.
// Edge-counted accumulator with saturation and sticky flags.
module plc_updown_counter #(
  parameter int unsigned ACC_W = 16,
  parameter logic [ACC_W-1:0] MAX_VAL = {ACC_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [ACC_W-1:0] preset,
  input  logic             cu_in,
  input  logic             cd_in,
  input  logic             load,
  input  logic             clr,
  output logic [ACC_W-1:0] acc,
  output logic             dn,
  output logic             cu,
  output logic             cd,
  output logic             ov,
  output logic             un
);

  typedef enum logic [1:0] {
    M_OFF = 2'b00,
    M_UP  = 2'b01,
    M_DN  = 2'b10,
    M_UD  = 2'b11
  } mode_e;

  localparam logic [ACC_W-1:0] ONE = ACC_W'(1);

  mode_e            mode_q;
  logic             cu_prev_q;
  logic             cd_prev_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             cu_q, cu_d;
  logic             cd_q, cd_d;
  logic             ov_q, ov_d;
  logic             un_q, un_d;

  logic up_ev, dn_ev;
  logic use_up, use_dn;
  logic mode_chg;

  assign up_ev    = cu_in & ~cu_prev_q;
  assign dn_ev    = cd_in & ~cd_prev_q;
  assign mode_chg = (mode != mode_q);
  assign use_up   = up_ev & mode_q[0];
  assign use_dn   = dn_ev & mode_q[1];

  // Next accumulator, pulse and flag state.
  always_comb begin
    acc_d = acc_q;
    cu_d  = 1'b0;
    cd_d  = 1'b0;
    ov_d  = ov_q;
    un_d  = un_q;
    if (mode_chg) begin
      acc_d = (mode == M_DN) ? preset : '0;
      ov_d  = 1'b0;
      un_d  = 1'b0;
    end else if (clr) begin
      acc_d = '0;
      ov_d  = 1'b0;
      un_d  = 1'b0;
    end else if (load) begin
      acc_d = preset;
      ov_d  = 1'b0;
      un_d  = 1'b0;
    end else if (enable && mode_q != M_OFF) begin
      if (use_up && use_dn) begin
        acc_d = acc_q;
      end else if (use_up) begin
        if (acc_q >= MAX_VAL) begin
          ov_d = 1'b1;
        end else begin
          acc_d = acc_q + ONE;
          cu_d  = 1'b1;
        end
      end else if (use_dn) begin
        if (acc_q == '0) begin
          un_d = 1'b1;
        end else begin
          acc_d = acc_q - ONE;
          cd_d  = 1'b1;
        end
      end
    end
  end

  // State registers; prev levels reset high so held inputs never count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= M_OFF;
      cu_prev_q <= 1'b1;
      cd_prev_q <= 1'b1;
      acc_q     <= '0;
      cu_q      <= 1'b0;
      cd_q      <= 1'b0;
      ov_q      <= 1'b0;
      un_q      <= 1'b0;
    end else begin
      mode_q    <= mode_e'(mode);
      cu_prev_q <= cu_in;
      cd_prev_q <= cd_in;
      acc_q     <= acc_d;
      cu_q      <= cu_d;
      cd_q      <= cd_d;
      ov_q      <= ov_d;
      un_q      <= un_d;
    end
  end

  // Done flag from registered mode and accumulator, live preset.
  always_comb begin
    dn = 1'b0;
    unique case (mode_q)
      M_UP:    dn = (acc_q >= preset);
      M_DN:    dn = (acc_q == '0);
      M_UD:    dn = (acc_q >= preset);
      default: dn = 1'b0;
    endcase
  end

  assign acc = acc_q;
  assign cu  = cu_q;
  assign cd  = cd_q;
  assign ov  = ov_q;
  assign un  = un_q;

endmodule

// File: tb/tb_plc_updown_counter.sv
// Bench for plc_updown_counter (ACC_W=8).
// Directed scenarios plus random traffic against a reference model.
module tb_plc_updown_counter;

  localparam int W   = 8;
  localparam int MAX = 255;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [1:0]   mode;
  logic [W-1:0] preset;
  logic         cu_in;
  logic         cd_in;
  logic         load;
  logic         clr;
  logic [W-1:0] acc;
  logic         dn;
  logic         cu;
  logic         cd;
  logic         ov;
  logic         un;

  int total;
  int bad;

  int m_acc, m_mode;
  bit m_cu, m_cd, m_ov, m_un;
  bit m_cup, m_cdp;

  plc_updown_counter #(.ACC_W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .preset (preset),
    .cu_in  (cu_in),
    .cd_in  (cd_in),
    .load   (load),
    .clr    (clr),
    .acc    (acc),
    .dn     (dn),
    .cu     (cu),
    .cd     (cd),
    .ov     (ov),
    .un     (un)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_dn();
    case (m_mode)
      1, 3:    return m_acc >= int'(preset);
      2:       return m_acc == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_acc  = 0;
    m_mode = 0;
    m_cu   = 0;
    m_cd   = 0;
    m_ov   = 0;
    m_un   = 0;
    m_cup  = 1;
    m_cdp  = 1;
  endtask

  // Behavioural rule set evaluated once per rising clock.
  task automatic model_step();
    bit rise_u, rise_d, want_u, want_d;
    rise_u = cu_in && !m_cup;
    rise_d = cd_in && !m_cdp;
    m_cu = 0;
    m_cd = 0;
    if (int'(mode) != m_mode) begin
      m_acc = (mode == 2'd2) ? int'(preset) : 0;
      m_ov  = 0;
      m_un  = 0;
    end else if (clr) begin
      m_acc = 0;
      m_ov  = 0;
      m_un  = 0;
    end else if (load) begin
      m_acc = int'(preset);
      m_ov  = 0;
      m_un  = 0;
    end else if (enable && m_mode != 0) begin
      want_u = rise_u && (m_mode == 1 || m_mode == 3);
      want_d = rise_d && (m_mode == 2 || m_mode == 3);
      if (want_u && !want_d) begin
        if (m_acc == MAX) m_ov = 1;
        else begin
          m_acc++;
          m_cu = 1;
        end
      end else if (want_d && !want_u) begin
        if (m_acc == 0) m_un = 1;
        else begin
          m_acc--;
          m_cd = 1;
        end
      end
    end
    m_mode = int'(mode);
    m_cup  = cu_in;
    m_cdp  = cd_in;
  endtask

  task automatic check_all(input string where);
    chk({where, ".acc"}, int'(acc), m_acc);
    chk({where, ".dn"},  int'(dn),  int'(model_dn()));
    chk({where, ".cu"},  int'(cu),  int'(m_cu));
    chk({where, ".cd"},  int'(cd),  int'(m_cd));
    chk({where, ".ov"},  int'(ov),  int'(m_ov));
    chk({where, ".un"},  int'(un),  int'(m_un));
  endtask

  task automatic cycle(input string where);
    @(posedge clk);
    model_step();
    #1;
    check_all(where);
  endtask

  task automatic up_pulse(input string where);
    cu_in = 1;
    cycle(where);
    cycle(where);
    cu_in = 0;
    cycle(where);
    cycle(where);
  endtask

  task automatic dn_pulse(input string where);
    cd_in = 1;
    cycle(where);
    cycle(where);
    cd_in = 0;
    cycle(where);
    cycle(where);
  endtask

  task automatic apply_reset();
    reset = 0;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    reset = 1;
  endtask

  int cu_hi;

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1;
    enable = 1;
    mode   = 2'd0;
    preset = '0;
    cu_in  = 0;
    cd_in  = 0;
    load   = 0;
    clr    = 0;
    model_reset();
    #2;
    apply_reset();

    // up count to preset 3
    mode   = 2'd1;
    preset = 8'd3;
    cycle("up_mc");
    cu_hi = 0;
    for (int i = 0; i < 4; i++) begin
      cu_in = 1;
      cycle("up");
      cu_hi += int'(cu);
      cycle("up");
      cu_hi += int'(cu);
      cu_in = 0;
      cycle("up");
      cu_hi += int'(cu);
      cycle("up");
      cu_hi += int'(cu);
    end
    chk("up_final_acc", int'(acc), 4);
    chk("up_final_dn", int'(dn), 1);
    chk("up_pulse_cycles", cu_hi, 4);

    // down from preset 2 to underflow
    mode   = 2'd2;
    preset = 8'd2;
    cycle("dn_mc");
    chk("dn_load_acc", int'(acc), 2);
    for (int i = 0; i < 3; i++) dn_pulse("dn");
    chk("dn_final_acc", int'(acc), 0);
    chk("dn_un", int'(un), 1);
    chk("dn_dn", int'(dn), 1);

    // saturation at FF then clear
    mode = 2'd1;
    cycle("sat_mc");
    preset = 8'hFF;
    load   = 1;
    cycle("sat_ld");
    load = 0;
    up_pulse("sat");
    chk("sat_acc", int'(acc), 255);
    chk("sat_ov", int'(ov), 1);
    clr = 1;
    cycle("sat_clr");
    clr = 0;
    chk("clr_acc", int'(acc), 0);
    chk("clr_ov", int'(ov), 0);
    chk("clr_dn", int'(dn), 0);

    // up/down cancel
    mode   = 2'd3;
    preset = 8'd5;
    cycle("ud_mc");
    load = 1;
    cycle("ud_ld");
    load  = 0;
    cu_in = 1;
    cd_in = 1;
    cycle("ud_both");
    chk("ud_cancel_acc", int'(acc), 5);
    chk("ud_cancel_cu", int'(cu), 0);
    cu_in = 0;
    cd_in = 0;
    cycle("ud_idle");
    up_pulse("ud_up");
    chk("ud_up_acc", int'(acc), 6);
    dn_pulse("ud_dn");
    chk("ud_dn_acc", int'(acc), 5);

    // held level across reset release and enable rise
    cu_in = 1;
    mode  = 2'd1;
    @(negedge clk);
    apply_reset();
    cycle("hold_mc");
    cycle("hold");
    enable = 0;
    cu_in  = 0;
    cycle("hold_en0");
    cu_in = 1;
    cycle("hold_en0");
    enable = 1;
    cycle("hold_en1");
    cycle("hold_en1");
    chk("hold_acc", int'(acc), 0);
    cu_in  = 0;
    preset = 8'd9;
    clr    = 1;
    load   = 1;
    cycle("clr_ld");
    clr  = 0;
    load = 0;
    chk("clr_ld_acc", int'(acc), 0);

    // async reset while counting
    for (int i = 0; i < 7; i++) up_pulse("pre_rst");
    chk("pre_rst_acc", int'(acc), 7);
    cu_in = 1;
    cycle("mid");
    apply_reset();
    chk("async_acc", int'(acc), 0);
    cu_in = 0;
    cycle("post_mc");
    cycle("post");
    up_pulse("post");
    chk("post_acc", int'(acc), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(31) == 0) mode = 2'($urandom);
      if ($urandom_range(15) == 0) preset = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(6));
      cu_in  = ($urandom_range(2) == 0) ? ~cu_in : cu_in;
      cd_in  = ($urandom_range(2) == 0) ? ~cd_in : cd_in;
      enable = ($urandom_range(7) != 0);
      clr    = ($urandom_range(63) == 0);
      load   = ($urandom_range(31) == 0);
      if ($urandom_range(499) == 0) begin
        @(negedge clk);
        #1;
        apply_reset();
      end
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
